// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU share arbiter: operation codes, FSM states and
// helpers used to size requester index fields.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam int CNT_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant and wraps; grant is
// one-hot and only asserted when en is high and some request is pending.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDXW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx
);

    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDXW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One 64-bit logic/add unit shared round-robin between NUM_REQ requesters.
// Optional per-requester accept counters: define ALU_ARB_PERF_EN.
//   state | meaning
//   IDLE  | no response held
//   RESP  | result/flags valid for owner_q, held until resp_ready[owner_q]
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     negative,
    output logic                     zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int IDXW = idx_width(NUM_REQ);

    arb_state_t       state_q, state_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [IDXW-1:0]  last_grant_q, last_grant_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;

    logic             can_accept;
    logic             accept;
    logic [IDXW-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_a, sel_b, alu_res;
    alu_op_t          sel_op;

    // A held response frees the unit in the same cycle its owner consumes it.
    assign can_accept = (state_q == IDLE) || resp_ready[owner_q];
    assign accept     = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         (can_accept),
        .grant      (req_ready),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_AND;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDXW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = alu_op_t'(req_op[2*i +: 2]);
            end
        end
    end

    always_comb begin
        alu_res = '0;
        case (sel_op)
            OP_AND:  alu_res = sel_a & sel_b;
            OP_OR:   alu_res = sel_a | sel_b;
            OP_XOR:  alu_res = sel_a ^ sel_b;
            OP_ADD:  alu_res = sel_a + sel_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        negative_d   = negative_q;
        zero_d       = zero_q;
        if (accept) begin
            state_d      = RESP;
            owner_d      = grant_idx;
            last_grant_d = grant_idx;
            result_d     = alu_res;
            negative_d   = alu_res[WIDTH-1];
            zero_d       = (alu_res == '0);
        end else if (state_q == RESP && resp_ready[owner_q]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            result_q     <= '0;
            negative_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            negative_q   <= negative_d;
            zero_q       <= zero_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    assign result   = result_q;
    assign negative = negative_q;
    assign zero     = zero_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_ready[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a cycle model checked on every
// falling edge plus directed vectors with literal expected values.
module tb_alu_share_arbiter;

    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         result;
    logic                     negative;
    logic                     zero;
`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ*32-1:0]    grant_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .negative   (negative),
        .zero       (zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Behavioural model: one pending response, round-robin pointer.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    logic [63:0] m_res;

    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] exp_rr, exp_rv;
        if (!rst_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NUM_REQ - 1;
            m_res   = '0;
            check("rst_resp_valid", resp_valid, 0);
            check("rst_result", result, 0);
            check("rst_flags", {negative, zero}, 0);
            if (req_valid == '0) check("rst_req_ready", req_ready, 0);
        end else begin
            exp_rv = '0;
            if (m_busy) exp_rv[m_owner] = 1'b1;
            g = -1;
            if (!m_busy || resp_ready[m_owner]) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (m_last + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            check("model_req_ready", req_ready, exp_rr);
            check("model_resp_valid", resp_valid, exp_rv);
            if (m_busy) begin
                check("model_result", result, m_res);
                check("model_negative", negative, m_res[63]);
                check("model_zero", zero, (m_res == 0));
            end
            if (g >= 0) begin
                m_res   = ref_alu(int'(req_op[2*g +: 2]), req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
                m_busy  = 1;
                m_owner = g;
                m_last  = g;
            end else if (m_busy && resp_ready[m_owner]) begin
                m_busy = 0;
            end
        end
    end

    task automatic set_req(input int idx, input int op, input logic [63:0] a, input logic [63:0] b);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[2*idx +: 2]        = 2'(op);
    endtask

    // Starts at the next rising edge; returns 1 ns after the accepting edge.
    task automatic issue(input int idx, input int op, input logic [63:0] a, input logic [63:0] b);
        bit got;
        @(posedge clk); #1;
        set_req(idx, op, a, b);
        req_valid[idx] = 1'b1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        check("issue_accept_timeout", got, 1);
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

        rst_n = 1'b0; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {req_ready, resp_valid, negative, zero}, 0);
        check("reset_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 2'b11;

        issue(0, 1, 64'hF0, 64'h0F);
        @(negedge clk);
        check("or_result", result, 64'hFF);
        check("or_resp_valid", resp_valid, 2'b01);
        check("or_flags", {negative, zero}, 2'b00);

        issue(1, 2, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        @(negedge clk);
        check("xor_result", result, 0);
        check("xor_zero", zero, 1);
        check("xor_resp_valid", resp_valid, 2'b10);

        issue(0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        @(negedge clk);
        check("add_wrap_result", result, 0);
        check("add_wrap_flags", {negative, zero}, 2'b01);

        issue(1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        @(negedge clk);
        check("and_result", result, 64'h8000_0000_0000_0000);
        check("and_flags", {negative, zero}, 2'b10);

        // Both requesters stream; last grant was requester 1.
        @(posedge clk); #1;
        set_req(0, 3, 64'd1, 64'd2);
        set_req(1, 1, 64'h100, 64'h011);
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("stream_grant", req_ready, exp_seq[n]);
            if (n > 0) check("stream_resp_valid", |resp_valid, 1);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("stream_last_resp", resp_valid, 2'b10);
        check("stream_last_result", result, 64'h111);

        // Owner 0 stalls its response while requester 1 waits.
        @(posedge clk); #1;
        resp_ready = 2'b00;
        issue(0, 0, 64'hFF00, 64'h0FF0);
        set_req(1, 2, 64'd5, 64'd3);
        req_valid[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("stall_result", result, 64'h0F00);
            check("stall_resp_valid", resp_valid, 2'b01);
            check("stall_req_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        check("release_req_ready", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("release_resp_valid", resp_valid, 2'b10);
        check("release_result", result, 64'h6);
        resp_ready = 2'b11;

        // Reset while a response is held.
        @(posedge clk); #1;
        resp_ready = 2'b00;
        issue(0, 3, 64'd5, 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_resp_valid", resp_valid, 0);
        check("midreset_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 2'b11;
        @(negedge clk);
        check("post_reset_resp_valid", resp_valid, 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 64-bit logic/add unit between `NUM_REQ` requesters, such as the execute stage and the address-generation unit of the pipelined CPU. It grants requesters round-robin and computes the selected operation. Result, negative and zero flags are registered, and the response is held until the owning requester accepts it. Throughput is one operation per cycle when responses are consumed immediately.

## Interface
- `WIDTH`, 64, operand/result width
- `NUM_REQ`, 2, number of requesters (2..8)
- `clk`  input  1  clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `req_valid`  input  NUM_REQ  per-requester request valid
- `req_ready`  output  NUM_REQ  per-requester accept; one-hot or zero
- `req_a`  input  NUM_REQ×WIDTH  operand A per requester
- `req_b`  input  NUM_REQ×WIDTH  operand B per requester
- `req_op`  input  NUM_REQ×2  op per requester: 0 AND, 1 OR, 2 XOR, 3 ADD
- `resp_valid`  output  NUM_REQ  response valid, one-hot to the owner of the transaction
- `resp_ready`  input  NUM_REQ  per-requester response accept
- `result`  output  WIDTH  registered result (shared bus)
- `negative`  output  1  `result[WIDTH-1]`, registered
- `zero`  output  1  high when `result == 0`, registered

## Operation
- FSM has two states:
  - IDLE: no response held.
  - RESP: `result`/flags valid for `owner`.
- Arbiter is round-robin over `req_valid`.
  - Search starts at `last_grant+1` and wraps mod NUM_REQ.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has first priority.
- Accept condition: `can_accept = (state==IDLE) | (state==RESP & resp_ready[owner])`.
  - `req_ready[g]=can_accept` only for the granted `g`; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `resp_ready`.
- On accept (`req_valid[g] & req_ready[g]`):
  - compute op on `req_a[g]`, `req_b[g]`;
  - register `result`, `negative`, `zero`;
  - `owner<=g`, `last_grant<=g`, state->RESP.
- ADD is modulo 2^WIDTH; carry out is discarded. AND/OR/XOR are bitwise.
- RESP with `resp_ready[owner]` and no accept -> IDLE. RESP without `resp_ready[owner]` holds all outputs stable.
- `resp_valid[i] = (state==RESP) & (owner==i)`. `resp_ready` bits of non-owners are ignored.
- Requests are never dropped. A requester holds `req_valid` and its operands until `req_ready`.

## Timing
- Latency: an accept at edge N gives `resp_valid` and `result` during cycle N+1.
- Back-to-back: consume at edge N+1 plus a new accept in the same cycle keeps `resp_valid` high continuously, owner changes at edge N+1.
- Reset (async assert, sync release) clears everything immediately:
  - state=IDLE, `last_grant`=NUM_REQ-1, `owner`=0;
  - `result`=0, `negative`=0, `zero`=0;
  - `resp_valid`=0; `req_ready`=0 while `req_valid`=0.
- Reset mid-transaction discards the held response; no `resp_valid` follows.
- All valid at once: grants rotate 0,1,…,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 accepts.

## Configuration
- `ALU_ARB_PERF_EN` defined: adds output `grant_cnt` (NUM_REQ×32).
  - One counter per requester, incremented on each accept.
  - Counters saturate at 2^32-1 and reset to 0 on `rst_n`.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Package `alu_arb_pkg`:
  - `alu_op_t` enum (OP_AND=0, OP_OR=1, OP_XOR=2, OP_ADD=3);
  - `arb_state_t` enum (IDLE, RESP).
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs `req`, `last_grant`, `en`; outputs one-hot `grant`, `grant_idx`.
- Datapath mux, op compute, FSM and output registers live in the top.

## Test plan
- Reset with `req_valid=0`:
  - all outputs 0, `req_ready=0`;
  - assert `rst_n` low mid-RESP -> `resp_valid` drops to 0 immediately.
- Req0 OR, A=0xF0, B=0x0F, `resp_ready=1`:
  - `resp_valid[0]` next cycle with `result`=0xFF, `zero`=0, `negative`=0.
- Req1 XOR, A=B=0xDEAD_BEEF:
  - `result`=0, `zero`=1.
- ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> `result`=0, `zero`=1.
- AND A=B=0x8000_0000_0000_0000 -> `negative`=1.
- Both requesters valid continuously with `resp_ready=1`:
  - grants alternate 0,1,0,1;
  - `resp_valid` high every cycle after the first.
- `resp_ready[owner]=0` for 3 cycles while req1 is valid:
  - `result` stable and `req_ready=0` throughout;
  - on release, req1 is accepted in the same cycle and its result appears the next cycle.
